// File: rtl/instr_byte_loader.sv
// instr_byte_loader: receives the byte-serial program-load stream, packs bytes
// little-endian into 32-bit words and writes them to consecutive instruction
// memory word addresses while holding the core stalled.
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing 8-bit checksum
// byte after the end marker or full condition).
module instr_byte_loader #(
    parameter int          ADDR_W     = 6,
    parameter logic [7:0]  START_BYTE = 8'hFE,
    parameter logic [7:0]  END_BYTE   = 8'hFF
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic [7:0]        instr_i,
    input  logic              byte_valid_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [31:0]       imem_wdata_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              load_full_o,
    output logic [ADDR_W:0]   word_count_o,
    output logic              checksum_err_o
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state;
    state_t              w_state_next;
    logic [1:0]          r_byte_cnt;
    logic [ADDR_W-1:0]   r_word_addr;
    logic [23:0]         r_partial;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_word_count;
    logic                r_full;
    logic                r_chk_err;

    logic w_take_start;
    logic w_in_load;
    logic w_end;
    logic w_data;
    logic w_word;
    logic w_last;

    // Decode what the current byte means in the current state.
    assign w_take_start = (r_state == S_IDLE) && byte_valid_i && (instr_i == START_BYTE);
    assign w_in_load    = (r_state == S_LOAD) && byte_valid_i;
    assign w_end        = w_in_load && (r_byte_cnt == 2'd0) && (instr_i == END_BYTE);
    assign w_data       = w_in_load && !w_end;
    assign w_word       = w_data && (r_byte_cnt == 2'd3);
    assign w_last       = w_word && (r_word_addr == LAST_ADDR);

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] w_chk_total;
    logic       w_chk_take;

    assign w_chk_total = r_sum + instr_i;
    assign w_chk_take  = (r_state == S_CHK) && byte_valid_i;

    // Running sum of data bytes and the verdict on the checksum byte.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_sum     <= 8'h00;
            r_chk_err <= 1'b0;
        end else begin
            if (w_take_start) begin
                r_sum <= 8'h00;
            end else if (w_data) begin
                r_sum <= r_sum + instr_i;
            end
            if (w_chk_take) begin
                r_chk_err <= (w_chk_total != 8'h00);
            end
        end
    end
`else
    assign r_chk_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: end marker or last word leaves LOAD; DONE is terminal.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_take_start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_end || w_last) begin
`ifdef LOADER_CHECKSUM_EN
                    w_state_next = S_CHK;
`else
                    w_state_next = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (byte_valid_i) begin
                    w_state_next = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_next = S_DONE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Byte packing, registered write port and load status.
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_cnt   <= 2'd0;
            r_word_addr  <= '0;
            r_partial    <= 24'h000000;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'h00000000;
            r_word_count <= '0;
            r_full       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_take_start) begin
                r_byte_cnt  <= 2'd0;
                r_word_addr <= '0;
                r_partial   <= 24'h000000;
            end else if (w_data) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_partial[7:0]   <= instr_i;
                    2'd1:    r_partial[15:8]  <= instr_i;
                    2'd2:    r_partial[23:16] <= instr_i;
                    default: r_partial        <= r_partial;
                endcase
                if (w_word) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_word_addr;
                    r_wdata <= {instr_i, r_partial};
                    if (r_word_count != MAX_COUNT) begin
                        r_word_count <= r_word_count + 1'b1;
                    end
                    if (w_last) begin
                        r_full <= 1'b1;
                    end else begin
                        r_word_addr <= r_word_addr + 1'b1;
                    end
                end
            end
        end
    end

    assign imem_we_o      = r_we;
    assign imem_addr_o    = r_addr;
    assign imem_wdata_o   = r_wdata;
    assign word_count_o   = r_word_count;
    assign load_full_o    = r_full;
    assign checksum_err_o = r_chk_err;
    assign cpu_hold_o     = (r_state != S_DONE) || r_chk_err;
    assign load_done_o    = (r_state == S_DONE) && !r_chk_err;

endmodule
